// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF->ID queue
// Signals:
//   i_if_valid, if_pc, if_inst, o_if_ready : fetch side (enqueue)
//   o_id_valid, id_pc, id_inst, i_id_ready : decode side (dequeue)
//   br_taken                               : flush request from branch resolution
//   o_count                                : queue occupancy for fetch throttling
// master drives the fetch/decode/branch inputs; slave is the queue itself.
interface if_id_queue_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 2
);
    logic              i_if_valid;
    logic              o_if_ready;
    logic              o_id_valid;
    logic              i_id_ready;
    logic              br_taken;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  o_count;

    modport master (
        output i_if_valid, i_id_ready, br_taken, if_pc, if_inst,
        input  o_if_ready, o_id_valid, id_pc, id_inst, o_count
    );

    modport slave (
        input  i_if_valid, i_id_ready, br_taken, if_pc, if_inst,
        output o_if_ready, o_id_valid, id_pc, id_inst, o_count
    );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - circular FIFO of {pc, inst} pairs between fetch and decode
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (wins over flush and handshakes)
//   bus : if_id_queue_if.slave, fetch enqueue / decode dequeue / flush / occupancy
module if_id_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_if_ready;
    logic w_id_valid;
    logic w_enq;
    logic w_deq;

    // Both flow-control outputs come from the count register alone, so the
    // upstream ready never sees decode's ready combinationally.
    assign w_if_ready = (r_count != CNT_W'(DEPTH));
    assign w_id_valid = (r_count != '0);
    assign w_enq      = bus.i_if_valid & w_if_ready;
    assign w_deq      = w_id_valid & bus.i_id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else if (bus.br_taken) begin
            // Storage is left as-is; the zero count hides stale entries.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_pc_mem[r_wr_ptr]   <= bus.if_pc;
                r_inst_mem[r_wr_ptr] <= bus.if_inst;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.o_if_ready = w_if_ready;
    assign bus.o_id_valid = w_id_valid;
    assign bus.o_count    = r_count;
    // An empty queue presents a bubble rather than stale storage.
    assign bus.id_pc      = w_id_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign bus.id_inst    = w_id_valid ? r_inst_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue at DEPTH=2 and DEPTH=4
module tb_if_id_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    if_id_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(2)) b2 ();
    if_id_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) b4 ();

    if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    logic [63:0] m2[$];
    logic [63:0] m4[$];
    logic [31:0] got2[$];
    bit d2, e2, d4, e4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for DEPTH=2: compare outputs against the model, capture
    // delivered pcs from the DUT, then advance the model by this cycle's inputs.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d2_count", 64'(b2.o_count), 64'(m2.size()));
            chk("d2_ready", 64'(b2.o_if_ready), 64'(m2.size() != 2));
            chk("d2_valid", 64'(b2.o_id_valid), 64'(m2.size() != 0));
            chk("d2_pc",   64'(b2.id_pc),   (m2.size() != 0) ? 64'(m2[0][63:32]) : 64'd0);
            chk("d2_inst", 64'(b2.id_inst), (m2.size() != 0) ? 64'(m2[0][31:0])  : 64'd0);
        end
        if (!rst && !b2.br_taken && b2.o_id_valid && b2.i_id_ready)
            got2.push_back(b2.id_pc);
        if (rst || b2.br_taken) begin
            m2.delete();
        end else begin
            d2 = (m2.size() != 0) && b2.i_id_ready;
            e2 = b2.i_if_valid && (m2.size() != 2);
            if (d2) void'(m2.pop_front());
            if (e2) m2.push_back({b2.if_pc, b2.if_inst});
        end
    end

    // Same reference FIFO for DEPTH=4.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d4_count", 64'(b4.o_count), 64'(m4.size()));
            chk("d4_ready", 64'(b4.o_if_ready), 64'(m4.size() != 4));
            chk("d4_valid", 64'(b4.o_id_valid), 64'(m4.size() != 0));
            chk("d4_pc",   64'(b4.id_pc),   (m4.size() != 0) ? 64'(m4[0][63:32]) : 64'd0);
            chk("d4_inst", 64'(b4.id_inst), (m4.size() != 0) ? 64'(m4[0][31:0])  : 64'd0);
        end
        if (rst || b4.br_taken) begin
            m4.delete();
        end else begin
            d4 = (m4.size() != 0) && b4.i_id_ready;
            e4 = b4.i_if_valid && (m4.size() != 4);
            if (d4) void'(m4.pop_front());
            if (e4) m4.push_back({b4.if_pc, b4.if_inst});
        end
    end

    task automatic push2(input logic [31:0] pc);
        b2.i_if_valid = 1'b1;
        b2.if_pc      = pc;
        b2.if_inst    = ~pc;
        tick();
        b2.i_if_valid = 1'b0;
    endtask

    logic [31:0] exp_pcs[$];

    task automatic chk_got(input string name);
        chk({name, "_n"}, 64'(got2.size()), 64'(exp_pcs.size()));
        for (int i = 0; i < exp_pcs.size() && i < got2.size(); i++)
            chk(name, 64'(got2[i]), 64'(exp_pcs[i]));
    endtask

    initial begin
        b2.i_if_valid = 0; b2.i_id_ready = 0; b2.br_taken = 0; b2.if_pc = 0; b2.if_inst = 0;
        b4.i_if_valid = 0; b4.i_id_ready = 0; b4.br_taken = 0; b4.if_pc = 0; b4.if_inst = 0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", 64'(b2.o_count), 64'd0);
        chk("rst_ready", 64'(b2.o_if_ready), 64'd1);
        chk("rst_valid", 64'(b2.o_id_valid), 64'd0);
        chk("rst_pc", 64'(b2.id_pc), 64'd0);

        // 1: reset mid-traffic
        push2(32'h10);
        push2(32'h14);
        chk("t1_full", 64'(b2.o_count), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t1_count", 64'(b2.o_count), 64'd0);
        chk("t1_valid", 64'(b2.o_id_valid), 64'd0);
        chk("t1_pc", 64'(b2.id_pc), 64'd0);
        chk("t1_inst", 64'(b2.id_inst), 64'd0);
        chk("t1_ready", 64'(b2.o_if_ready), 64'd1);

        // 2: fill and stall
        got2.delete();
        push2(32'h1c000000);
        push2(32'h1c000004);
        chk("t2_count", 64'(b2.o_count), 64'd2);
        chk("t2_ready", 64'(b2.o_if_ready), 64'd0);
        push2(32'h1c000008);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_pc", 64'(b2.id_pc), 64'h1c000000);
            chk("t2_hold_cnt", 64'(b2.o_count), 64'd2);
        end
        b2.i_id_ready = 1'b1;
        tick(); tick();
        b2.i_id_ready = 1'b0;
        exp_pcs = '{32'h1c000000, 32'h1c000004};
        chk_got("t2_order");

        // 3: streaming through both wraps
        got2.delete();
        b2.i_id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push2(32'h100 + 32'(4 * i));
            chk("t3_cnt_le1", 64'(b2.o_count <= 2'd1), 64'd1);
        end
        tick();
        b2.i_id_ready = 1'b0;
        exp_pcs = '{32'h100, 32'h104, 32'h108, 32'h10c, 32'h110, 32'h114};
        chk_got("t3_order");

        // 4: full with simultaneous enqueue attempt and dequeue
        got2.delete();
        push2(32'h400);
        push2(32'h404);
        chk("t4_full", 64'(b2.o_count), 64'd2);
        b2.i_id_ready = 1'b1;
        b2.i_if_valid = 1'b1;
        b2.if_pc = 32'h408; b2.if_inst = ~32'h408;
        tick();
        b2.i_id_ready = 1'b0;
        chk("t4_count", 64'(b2.o_count), 64'd1);
        chk("t4_ready", 64'(b2.o_if_ready), 64'd1);
        tick();
        b2.i_if_valid = 1'b0;
        chk("t4_count2", 64'(b2.o_count), 64'd2);
        chk("t4_head", 64'(b2.id_pc), 64'h404);
        b2.i_id_ready = 1'b1;
        tick(); tick();
        b2.i_id_ready = 1'b0;
        exp_pcs = '{32'h400, 32'h404, 32'h408};
        chk_got("t4_order");

        // 5: flush with simultaneous enq and deq
        got2.delete();
        push2(32'h500);
        push2(32'h504);
        b2.i_if_valid = 1'b1; b2.if_pc = 32'h200; b2.if_inst = ~32'h200;
        b2.i_id_ready = 1'b1;
        b2.br_taken   = 1'b1;
        tick();
        b2.br_taken = 1'b0; b2.i_id_ready = 1'b0; b2.i_if_valid = 1'b0;
        chk("t5_count", 64'(b2.o_count), 64'd0);
        chk("t5_valid", 64'(b2.o_id_valid), 64'd0);
        chk("t5_inst", 64'(b2.id_inst), 64'd0);
        push2(32'h300);
        chk("t5_head", 64'(b2.id_pc), 64'h300);
        b2.i_id_ready = 1'b1;
        tick();
        b2.i_id_ready = 1'b0;
        exp_pcs = '{32'h300};
        chk_got("t5_order");

        // sustained flush keeps the queue empty and ready
        b2.br_taken = 1'b1; b2.i_if_valid = 1'b1; b2.if_pc = 32'h600;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("brh_count", 64'(b2.o_count), 64'd0);
            chk("brh_ready", 64'(b2.o_if_ready), 64'd1);
        end
        b2.br_taken = 1'b0; b2.i_if_valid = 1'b0;
        tick();

        // 6: DEPTH=4 random traffic against the reference FIFO
        for (int i = 0; i < 10000; i++) begin
            b4.i_if_valid = ($urandom_range(0, 99) < 30);
            b4.i_id_ready = ($urandom_range(0, 99) < 30);
            b4.br_taken   = ($urandom_range(0, 99) < 30);
            b4.if_pc      = $urandom;
            b4.if_inst    = $urandom;
            tick();
        end
        b4.i_if_valid = 0; b4.i_id_ready = 0; b4.br_taken = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
